// File: rtl/sensor_dvp_pattern_gen_pkg.sv
// Shared types, pattern codes and pixel generator for the DVP pattern source.
package sensor_dvp_pattern_gen_pkg;

   localparam int ACC_W = 28;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_VS_PRE  = 2'd1,
      ST_ACTIVE  = 2'd2,
      ST_VS_POST = 2'd3
   } state_t;

   localparam logic [1:0] PAT_HRAMP = 2'd0;
   localparam logic [1:0] PAT_VRAMP = 2'd1;
   localparam logic [1:0] PAT_CHECK = 2'd2;
   localparam logic [1:0] PAT_FLAT  = 2'd3;

   // Pixel value for a given pattern, horizontal position and active-line index.
   function automatic logic [7:0] pattern_pixel(input logic [1:0] sel,
                                                input logic [7:0] h,
                                                input logic [7:0] line);
      logic [7:0] px;
      case (sel)
         PAT_HRAMP: px = h;
         PAT_VRAMP: px = line;
         PAT_CHECK: px = {8{h[4] ^ line[4]}};
         PAT_FLAT:  px = 8'h80;
         default:   px = 8'h00;
      endcase
      return px;
   endfunction

endpackage

// File: rtl/sensor_dvp_pattern_gen_frame_rate_tick.sv
// Fractional rate accumulator: one registered tick every CLOCK_MAIN/fps_set cycles on average.
module frame_rate_tick
   import sensor_dvp_pattern_gen_pkg::*;
#(
   parameter int CLOCK_MAIN = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       gen_en,
   input  logic [7:0] fps_set,
   output logic       tick
);

   localparam logic [ACC_W:0] LIMIT = (ACC_W + 1)'(CLOCK_MAIN);

   logic [ACC_W-1:0] r_acc;
   logic             r_tick;
   logic [ACC_W:0]   w_sum;
   logic [ACC_W:0]   w_diff;

   assign w_sum  = {1'b0, r_acc} + {{(ACC_W - 7){1'b0}}, fps_set};
   assign w_diff = w_sum - LIMIT;

   // Accumulate and wrap; the remainder is kept so the long-term rate never drifts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc  <= {ACC_W{1'b0}};
         r_tick <= 1'b0;
      end else if (!gen_en) begin
         r_acc  <= {ACC_W{1'b0}};
         r_tick <= 1'b0;
      end else if (w_sum >= LIMIT) begin
         r_acc  <= w_diff[ACC_W-1:0];
         r_tick <= 1'b1;
      end else begin
         r_acc  <= w_sum[ACC_W-1:0];
         r_tick <= 1'b0;
      end
   end

   assign tick = r_tick;

endmodule

// File: rtl/sensor_dvp_pattern_gen.sv
// DVP frame source: rate-paced frame starts, fixed geometry, selectable test patterns.
module sensor_dvp_pattern_gen
   import sensor_dvp_pattern_gen_pkg::*;
#(
   parameter int CLOCK_MAIN = 100_000_000,
   parameter int H_ACTIVE   = 1280,
   parameter int H_TOTAL    = 1650,
   parameter int V_PRE      = 2,
   parameter int V_ACTIVE   = 960,
   parameter int V_POST     = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       gen_en,
   input  logic [7:0] fps_set,
   input  logic [1:0] pattern_sel,
   output logic       cmos_vsync,
   output logic       cmos_href,
   output logic [7:0] cmos_data,
   output logic       fps_overrun
);

   localparam int H_W   = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int V_MAX = (V_ACTIVE > V_PRE) ? ((V_ACTIVE > V_POST) ? V_ACTIVE : V_POST)
                                             : ((V_PRE > V_POST) ? V_PRE : V_POST);
   localparam int V_W   = $clog2(V_MAX + 1);

   localparam logic [H_W-1:0] H_LAST        = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0] H_ACT         = H_W'(H_ACTIVE);
   localparam logic [V_W-1:0] V_PRE_LAST    = V_W'(V_PRE - 1);
   localparam logic [V_W-1:0] V_ACTIVE_LAST = V_W'(V_ACTIVE - 1);
   localparam logic [V_W-1:0] V_POST_LAST   = V_W'(V_POST - 1);
   localparam state_t         ST_FIRST      = (V_PRE > 0) ? ST_VS_PRE : ST_ACTIVE;
   localparam state_t         ST_AFTER_ACT  = (V_POST > 0) ? ST_VS_POST : ST_IDLE;

   logic           w_tick;
   state_t         r_state;
   state_t         w_state_nx;
   state_t         w_after;
   logic [H_W-1:0] r_h_cnt;
   logic [H_W-1:0] w_h_nx;
   logic [V_W-1:0] r_v_cnt;
   logic [V_W-1:0] w_v_nx;
   logic [V_W-1:0] w_v_last;
   logic [1:0]     r_pat;
   logic [1:0]     w_pat_nx;
   logic           w_run;
   logic           w_href_nx;
   logic [7:0]     w_data_nx;
   logic           r_vsync;
   logic           r_href;
   logic [7:0]     r_data;
   logic           r_overrun;

   frame_rate_tick #(
      .CLOCK_MAIN (CLOCK_MAIN)
   ) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .gen_en  (gen_en),
      .fps_set (fps_set),
      .tick    (w_tick)
   );

   // Next-state and counter logic; each non-idle state lasts a fixed number of whole lines.
   always_comb begin
      w_state_nx = r_state;
      w_h_nx     = r_h_cnt;
      w_v_nx     = r_v_cnt;
      w_pat_nx   = r_pat;
      w_v_last   = V_PRE_LAST;
      w_after    = ST_IDLE;
      w_run      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_h_nx = {H_W{1'b0}};
            w_v_nx = {V_W{1'b0}};
            if (w_tick) begin
               w_state_nx = ST_FIRST;
               w_pat_nx   = pattern_sel;
            end else begin
               w_state_nx = ST_IDLE;
            end
         end
         ST_VS_PRE: begin
            w_v_last = V_PRE_LAST;
            w_after  = ST_ACTIVE;
            w_run    = 1'b1;
         end
         ST_ACTIVE: begin
            w_v_last = V_ACTIVE_LAST;
            w_after  = ST_AFTER_ACT;
            w_run    = 1'b1;
         end
         ST_VS_POST: begin
            w_v_last = V_POST_LAST;
            w_after  = ST_IDLE;
            w_run    = 1'b1;
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
      if (w_run) begin
         if (r_h_cnt == H_LAST) begin
            w_h_nx = {H_W{1'b0}};
            if (r_v_cnt == w_v_last) begin
               w_v_nx     = {V_W{1'b0}};
               w_state_nx = w_after;
            end else begin
               w_v_nx = r_v_cnt + V_W'(1);
            end
         end else begin
            w_h_nx = r_h_cnt + H_W'(1);
         end
      end else begin
         w_run = 1'b0;
      end
   end

   // Outputs are decoded from next-state values so they register in step with the FSM.
   assign w_href_nx = (w_state_nx == ST_ACTIVE) && (w_h_nx < H_ACT);
   assign w_data_nx = w_href_nx ? pattern_pixel(w_pat_nx, 8'(w_h_nx), 8'(w_v_nx)) : 8'h00;

   // FSM state, position counters and the per-frame pattern latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_h_cnt <= {H_W{1'b0}};
         r_v_cnt <= {V_W{1'b0}};
         r_pat   <= PAT_HRAMP;
      end else begin
         r_state <= w_state_nx;
         r_h_cnt <= w_h_nx;
         r_v_cnt <= w_v_nx;
         r_pat   <= w_pat_nx;
      end
   end

   // Registered video outputs and the sticky dropped-tick flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsync   <= 1'b0;
         r_href    <= 1'b0;
         r_data    <= 8'h00;
         r_overrun <= 1'b0;
      end else begin
         r_vsync <= (w_state_nx != ST_IDLE);
         r_href  <= w_href_nx;
         r_data  <= w_data_nx;
         if (!gen_en) begin
            r_overrun <= 1'b0;
         end else if (w_tick && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
         end else begin
            r_overrun <= r_overrun;
         end
      end
   end

   assign cmos_vsync  = r_vsync;
   assign cmos_href   = r_href;
   assign cmos_data   = r_data;
   assign fps_overrun = r_overrun;

endmodule
